dc_flow_ctrl: RTL and testbench
===============================

// Module: dc_flow_ctrl
// PURPOSE
//  Sequences the SPARC decode stage: owns the architectural fetch/decode rip and gates can_decode.
//  Tracks delayed control transfers (branch + one delay slot) and serialising ops (save/restore/rett/ticc).
//  Applies backend redirects and issues the one-cycle dc_resume that releases the decoder from dc_stall.
//  Sits between the fetch byte window and Decoder.
// PARAMETERS
//  RESET_RIP   64'h0  rip loaded on reset
//  STALL_CNT_W 32     width of the saturating stall-cycle counter
// PORTS
//  clk              in   1   clock (single domain)
//  reset            in   1   asynchronous, active-high reset
//  fetch_valid      in   1   decode byte window for current rip is valid
//  dc_bytes_decoded in   8   bytes consumed by decoder this cycle (0 or 4)
//  dc_ctl_class     in   2   class of decoded instr: 0 normal, 1 delayed CTI, 2 serialising, 3 reserved
//  redirect_valid   in   1   backend resolved a CTI/trap; redirect_rip is the new rip
//  redirect_rip     in   64  redirect target
//  serialize_done   in   1   serialising instr retired; pipeline may restart
//  can_decode       out  1   decoder may consume bytes at rip this cycle
//  rip              out  64  address of instr being decoded
//  dc_resume        out  1   one-cycle pulse releasing decoder from stall
//  flush            out  1   one-cycle pulse: discard younger fetched/decoded work
//  misalign_err     out  1   sticky: redirect_rip[1:0]!=0 seen
//  stall_cycles     out  STALL_CNT_W  count of cycles with can_decode=0, saturating
// BEHAVIOUR
//  Reset (async, any state): state=RUN, rip=RESET_RIP, pend_v=0, all pulses 0, misalign_err=0,
//    stall_cycles=0; can_decode=0 while reset high.
//  can_decode = fetch_valid & (state==RUN | state==DSLOT) & !misalign_err (combinational).
//  A decode event is can_decode & dc_bytes_decoded!=0; on it rip <= rip + dc_bytes_decoded (64-bit wrap).
//  States:
//   RUN:   event class 0 -> stay; class 1 -> DSLOT; class 2 -> SERIAL; class 3 -> treat as 2.
//   DSLOT: next decode event is the delay slot (class ignored) -> WAITR; rip += 4.
//   WAITR: can_decode=0. On redirect_valid (or pend_v): rip<=target, flush=1 next cycle, -> RUN.
//   SERIAL: can_decode=0. On serialize_done: dc_resume=1 for exactly one cycle, -> RUN;
//      if redirect_valid same cycle, rip<=redirect_rip and flush=1 as well.
//   HALT:  entered when misalign_err sets; can_decode=0 until reset.
//  Redirect rules:
//   RUN: redirect_valid has priority over the decode event that cycle: rip<=redirect_rip, flush, event dropped.
//   DSLOT: redirect is latched into pend (pend_v=1); delay slot still decodes; WAITR then applies pend
//     in its first cycle (no extra wait). A second redirect before apply overwrites pend.
//   SERIAL without serialize_done: redirect latched into pend, applied with dc_resume.
//  Any redirect with redirect_rip[1:0]!=0: misalign_err<=1, state->HALT, rip unchanged, no flush.
//  dc_resume and flush are registered: asserted the cycle after the triggering input, never >1 cycle.
//  stall_cycles increments each cycle can_decode=0 while not in reset; holds at all-ones.
// TESTING
//  1 Reset RESET_RIP=0x1000, fetch_valid=1, three class-0 decodes of 4 -> rip 0x1004,0x1008,0x100C.
//  2 Class-1 at 0x2000, delay slot decodes, redirect 0x3000 two cycles later -> rip 0x2004,0x2008, then
//    0x3000, flush pulse one cycle, can_decode low only in WAITR.
//  3 Redirect 0x4000 arrives during DSLOT -> delay slot still decoded, WAITR lasts 1 cycle, rip=0x4000.
//  4 Class-2 (save) -> can_decode low; serialize_done after 5 cycles -> single dc_resume, stall_cycles=6.
//  5 Redirect 0x5002 -> misalign_err=1, HALT, can_decode stays 0; async reset mid-HALT clears all.
//  6 RUN redirect coincident with decode event -> rip=redirect_rip, no +4 applied.

Source files
------------

// File: rtl/dc_flow_ctrl_if.sv
// Decode-stage flow-control bundle: fetch window, decoder feedback and backend redirects
// on one side, decode gating and rip/status on the other.
interface dc_flow_ctrl_if #(
  parameter int STALL_CNT_W = 32
);
  logic                   fetch_valid;
  logic [7:0]             dc_bytes_decoded;
  logic [1:0]             dc_ctl_class;
  logic                   redirect_valid;
  logic [63:0]            redirect_rip;
  logic                   serialize_done;
  logic                   can_decode;
  logic [63:0]            rip;
  logic                   dc_resume;
  logic                   flush;
  logic                   misalign_err;
  logic [STALL_CNT_W-1:0] stall_cycles;

  modport master (
    output fetch_valid, dc_bytes_decoded, dc_ctl_class,
    output redirect_valid, redirect_rip, serialize_done,
    input  can_decode, rip, dc_resume, flush, misalign_err, stall_cycles
  );

  modport slave (
    input  fetch_valid, dc_bytes_decoded, dc_ctl_class,
    input  redirect_valid, redirect_rip, serialize_done,
    output can_decode, rip, dc_resume, flush, misalign_err, stall_cycles
  );
endinterface

// File: rtl/dc_flow_ctrl.sv
// SPARC decode-stage sequencer: owns rip, gates can_decode, tracks delay slots,
// serialising ops and backend redirects, and counts stalled cycles.
module dc_flow_ctrl #(
  parameter logic [63:0] RESET_RIP   = 64'h0,
  parameter int          STALL_CNT_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  dc_flow_ctrl_if.slave fc
);

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_DSLOT  = 3'd1,
    ST_WAITR  = 3'd2,
    ST_SERIAL = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  state_t                 state, state_nxt;
  logic [63:0]            rip, rip_nxt;
  logic [63:0]            pend_rip, pend_rip_nxt;
  logic                   pend_v, pend_v_nxt;
  logic                   flush, flush_nxt;
  logic                   resume, resume_nxt;
  logic                   err, err_nxt;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic                   can_dec;
  logic                   dec_ev;
  logic                   redir_ok;
  logic                   redir_bad;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign can_dec   = fc.fetch_valid & ((state == ST_RUN) | (state == ST_DSLOT)) & ~err & ~reset;
  assign dec_ev    = can_dec & (fc.dc_bytes_decoded != 8'd0);
  assign redir_ok  = fc.redirect_valid & (fc.redirect_rip[1:0] == 2'b00);
  assign redir_bad = fc.redirect_valid & (fc.redirect_rip[1:0] != 2'b00);

  always_comb begin
    state_nxt    = state;
    rip_nxt      = rip;
    pend_rip_nxt = pend_rip;
    pend_v_nxt   = pend_v;
    flush_nxt    = 1'b0;
    resume_nxt   = 1'b0;
    err_nxt      = err;
    if (redir_bad) begin
      // A misaligned target poisons the stream: no flush, rip frozen until reset.
      err_nxt    = 1'b1;
      state_nxt  = ST_HALT;
      pend_v_nxt = 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (redir_ok) begin
            rip_nxt   = fc.redirect_rip;
            flush_nxt = 1'b1;
          end else if (dec_ev) begin
            rip_nxt = rip + {56'h0, fc.dc_bytes_decoded};
            case (fc.dc_ctl_class)
              2'd0:    state_nxt = ST_RUN;
              2'd1:    state_nxt = ST_DSLOT;
              default: state_nxt = ST_SERIAL;
            endcase
          end
        end
        ST_DSLOT: begin
          if (redir_ok) begin
            pend_rip_nxt = fc.redirect_rip;
            pend_v_nxt   = 1'b1;
          end
          if (dec_ev) begin
            rip_nxt   = rip + {56'h0, fc.dc_bytes_decoded};
            state_nxt = ST_WAITR;
          end
        end
        ST_WAITR: begin
          // A live redirect is newer than anything parked during the delay slot.
          if (redir_ok || pend_v) begin
            rip_nxt    = redir_ok ? fc.redirect_rip : pend_rip;
            flush_nxt  = 1'b1;
            pend_v_nxt = 1'b0;
            state_nxt  = ST_RUN;
          end
        end
        ST_SERIAL: begin
          if (fc.serialize_done) begin
            resume_nxt = 1'b1;
            pend_v_nxt = 1'b0;
            state_nxt  = ST_RUN;
            if (redir_ok || pend_v) begin
              rip_nxt   = redir_ok ? fc.redirect_rip : pend_rip;
              flush_nxt = 1'b1;
            end
          end else if (redir_ok) begin
            pend_rip_nxt = fc.redirect_rip;
            pend_v_nxt   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      rip       <= RESET_RIP;
      pend_v    <= 1'b0;
      flush     <= 1'b0;
      resume    <= 1'b0;
      err       <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state  <= state_nxt;
      rip    <= rip_nxt;
      pend_v <= pend_v_nxt;
      flush  <= flush_nxt;
      resume <= resume_nxt;
      err    <= err_nxt;
      if (!can_dec) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  // Parked redirect target is qualified by pend_v, so it carries no reset.
  always_ff @(posedge clk) begin
    pend_rip <= pend_rip_nxt;
  end

  assign fc.can_decode   = can_dec;
  assign fc.rip          = rip;
  assign fc.dc_resume    = resume;
  assign fc.flush        = flush;
  assign fc.misalign_err = err;
  assign fc.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_dc_flow_ctrl.sv
// Bench for dc_flow_ctrl: directed scenarios plus randomized traffic against a
// behavioural model of the decode-stage sequencing rules.
module tb_dc_flow_ctrl;
  localparam logic [63:0] RST_RIP = 64'h1000;
  localparam int          SW      = 8;
  localparam int          SAT     = (1 << SW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dc_flow_ctrl_if #(.STALL_CNT_W(SW)) fc ();
  dc_flow_ctrl #(.RESET_RIP(RST_RIP), .STALL_CNT_W(SW)) dut (.clk(clk), .reset(reset), .fc(fc));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: phase of the decode stream plus a one-deep redirect mailbox.
  typedef enum int {M_RUN, M_SLOT, M_WAIT, M_SER, M_HALT} mphase_t;
  mphase_t     ph;
  logic [63:0] m_rip;
  logic [63:0] pendq[$];
  bit          m_err, m_flush, m_resume;
  int          m_stall;

  function automatic bit m_can(input bit fv);
    return fv && (ph == M_RUN || ph == M_SLOT) && !m_err;
  endfunction

  function automatic void park(input logic [63:0] t);
    pendq.delete();
    pendq.push_back(t);
  endfunction

  function automatic void model_step(input bit fv, input logic [7:0] by, input logic [1:0] cls,
                                     input bit rv, input logic [63:0] rr, input bit sd);
    bit cd   = m_can(fv);
    bit ev   = cd && (by != 8'd0);
    bit bad  = rv && (rr[1:0] != 2'b00);
    bit good = rv && !bad;
    m_flush  = 0;
    m_resume = 0;
    if (!cd) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
    if (bad) begin
      m_err = 1;
      ph    = M_HALT;
      pendq.delete();
      return;
    end
    if (ph == M_RUN) begin
      if (good) begin
        m_rip   = rr;
        m_flush = 1;
      end else if (ev) begin
        m_rip = m_rip + 64'(by);
        ph = (cls == 2'd0) ? M_RUN : (cls == 2'd1) ? M_SLOT : M_SER;
      end
    end else if (ph == M_SLOT) begin
      if (good) park(rr);
      if (ev) begin
        m_rip = m_rip + 64'(by);
        ph = M_WAIT;
      end
    end else if (ph == M_WAIT) begin
      if (good) park(rr);
      if (pendq.size() != 0) begin
        m_rip   = pendq.pop_back();
        m_flush = 1;
        ph      = M_RUN;
      end
    end else if (ph == M_SER) begin
      if (good) park(rr);
      if (sd) begin
        m_resume = 1;
        ph       = M_RUN;
        if (pendq.size() != 0) begin
          m_rip   = pendq.pop_back();
          m_flush = 1;
        end
        pendq.delete();
      end
    end
  endfunction

  task automatic check_regs();
    chk("rip", fc.rip, m_rip);
    chk("flush", 64'(fc.flush), 64'(m_flush));
    chk("dc_resume", 64'(fc.dc_resume), 64'(m_resume));
    chk("misalign_err", 64'(fc.misalign_err), 64'(m_err));
    chk("stall_cycles", 64'(fc.stall_cycles), 64'(m_stall));
  endtask

  task automatic cycle(input bit fv, input logic [7:0] by, input logic [1:0] cls,
                       input bit rv, input logic [63:0] rr, input bit sd);
    fc.fetch_valid      = fv;
    fc.dc_bytes_decoded = by;
    fc.dc_ctl_class     = cls;
    fc.redirect_valid   = rv;
    fc.redirect_rip     = rr;
    fc.serialize_done   = sd;
    #1;
    chk("can_decode", 64'(fc.can_decode), 64'(m_can(fv)));
    model_step(fv, by, cls, rv, rr, sd);
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    fc.fetch_valid      = 1'b1;
    fc.dc_bytes_decoded = 8'd0;
    fc.dc_ctl_class     = 2'd0;
    fc.redirect_valid   = 1'b0;
    fc.redirect_rip     = 64'h0;
    fc.serialize_done   = 1'b0;
    reset = 1'b1;
    #1;
    ph = M_RUN; m_rip = RST_RIP; pendq.delete();
    m_err = 0; m_flush = 0; m_resume = 0; m_stall = 0;
    chk("rst_can_decode", 64'(fc.can_decode), 64'd0);
    check_regs();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] rr;
    reset = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Straight-line decode
    cycle(1, 4, 0, 0, 0, 0); chk("t1_rip0", fc.rip, 64'h1004);
    cycle(1, 4, 0, 0, 0, 0); chk("t1_rip1", fc.rip, 64'h1008);
    cycle(1, 4, 0, 0, 0, 0); chk("t1_rip2", fc.rip, 64'h100C);

    // Delayed CTI with late redirect
    cycle(1, 0, 0, 1, 64'h2000, 0);
    cycle(1, 4, 1, 0, 0, 0); chk("t2_rip_cti", fc.rip, 64'h2004);
    cycle(1, 4, 0, 0, 0, 0); chk("t2_rip_slot", fc.rip, 64'h2008);
    cycle(1, 4, 0, 0, 0, 0); chk("t2_waitr_hold", fc.rip, 64'h2008);
    cycle(1, 4, 0, 1, 64'h3000, 0);
    chk("t2_rip_tgt", fc.rip, 64'h3000);
    chk("t2_flush", 64'(fc.flush), 64'd1);
    cycle(1, 0, 0, 0, 0, 0); chk("t2_flush_off", 64'(fc.flush), 64'd0);

    // Redirect parked during delay slot
    cycle(1, 4, 1, 0, 0, 0);
    cycle(1, 4, 0, 1, 64'h4000, 0); chk("t3_slot_rip", fc.rip, 64'h3008);
    cycle(1, 4, 0, 0, 0, 0);
    chk("t3_rip", fc.rip, 64'h4000);
    chk("t3_flush", 64'(fc.flush), 64'd1);

    // Serialising op
    do_reset();
    cycle(1, 4, 2, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 4, 0, 0, 0, 0);
    cycle(1, 4, 0, 0, 0, 1);
    chk("t4_resume", 64'(fc.dc_resume), 64'd1);
    chk("t4_stall", 64'(fc.stall_cycles), 64'd6);
    cycle(1, 0, 0, 0, 0, 0); chk("t4_resume_off", 64'(fc.dc_resume), 64'd0);

    // Misaligned redirect halts until reset
    cycle(1, 4, 0, 1, 64'h5002, 0);
    chk("t5_err", 64'(fc.misalign_err), 64'd1);
    chk("t5_flush", 64'(fc.flush), 64'd0);
    for (int i = 0; i < 3; i++) cycle(1, 4, 0, 0, 0, 0);
    chk("t5_halt_can", 64'(fc.can_decode), 64'd0);
    do_reset();
    chk("t5_rst_err", 64'(fc.misalign_err), 64'd0);

    // Redirect beats a coincident decode event
    cycle(1, 4, 0, 1, 64'h6000, 0); chk("t6_rip", fc.rip, 64'h6000);

    // Stall counter saturation
    for (int i = 0; i < SAT + 6; i++) cycle(0, 4, 0, 0, 0, 0);
    chk("sat_stall", 64'(fc.stall_cycles), 64'(SAT));

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ((ph == M_HALT && $urandom_range(0, 3) == 0) || $urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        rr = {$urandom, $urandom} & ~64'h3;
        if ($urandom_range(0, 15) == 0) rr[1:0] = 2'($urandom_range(1, 3));
        cycle(bit'($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0) ? 8'd4 : 8'd0,
              2'($urandom_range(0, 3)), bit'($urandom_range(0, 7) == 0), rr,
              bit'($urandom_range(0, 3) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
